// File: rtl/systolic_result_drain.sv
// Collects 3-row results from the 3x3 systolic array into whole matrices and
// streams the buffered elements out row-major over a valid/ready handshake.
module systolic_result_drain #(
    parameter int unsigned data_size = 8,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [data_size*6-1:0]       row_in,
    input  logic                         row_valid,
    input  logic                         flush,
    output logic [2*data_size-1:0]       out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_row,
    output logic [1:0]                   out_col,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int unsigned EW     = 2 * data_size;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS  = DEPTH * 9;
    localparam int unsigned ADDR_W = $clog2(SLOTS);

    logic [EW-1:0]     mem_q [SLOTS];

    logic [1:0]        wr_row_q, wr_row_d;
    logic              drop_q, drop_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]        e_q, e_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;

    logic              full;
    logic              wr_en;
    logic              commit;
    logic              xfer;
    logic              xfer_last;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        e_row;
    logic [1:0]        e_col;

    // Full is only consulted at row 0, where no matrix is in progress.
    assign full      = (level_q == LVL_W'(DEPTH));
    assign wr_en     = row_valid && !flush && !drop_q && !((wr_row_q == 2'd0) && full);
    assign commit    = wr_en && (wr_row_q == 2'd2);
    assign xfer      = (level_q != '0) && out_ready && !flush;
    assign xfer_last = xfer && (e_q == 4'd8);

    assign wr_addr = ADDR_W'(wr_ptr_q) * ADDR_W'(9) + ADDR_W'(wr_row_q) * ADDR_W'(3);
    assign rd_addr = ADDR_W'(rd_ptr_q) * ADDR_W'(9) + ADDR_W'(e_q);

    always_comb begin
        e_row = 2'd0;
        if (e_q >= 4'd6) begin
            e_row = 2'd2;
        end else if (e_q >= 4'd3) begin
            e_row = 2'd1;
        end
        e_col = 2'(e_q - 4'(e_row) * 4'd3);
    end

    always_comb begin
        wr_row_d   = wr_row_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        e_d        = e_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_row_d   = 2'd0;
            drop_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            e_d        = 4'd0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Dropped matrices still advance wr_row so rows 1 and 2 are swallowed.
            if (row_valid) begin
                wr_row_d = (wr_row_q == 2'd2) ? 2'd0 : wr_row_q + 2'd1;
                if (wr_row_q == 2'd2) begin
                    drop_d = 1'b0;
                end else if ((wr_row_q == 2'd0) && full) begin
                    drop_d     = 1'b1;
                    overflow_d = 1'b1;
                end
            end
            if (commit) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (xfer) begin
                e_d = (e_q == 4'd8) ? 4'd0 : e_q + 4'd1;
            end
            if (xfer_last) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({commit, xfer_last})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row_q   <= 2'd0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            e_q        <= 4'd0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_row_q   <= wr_row_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            e_q        <= e_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Matrix storage, not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < 3; j++) begin
                mem_q[wr_addr + ADDR_W'(j)] <= row_in[j*EW +: EW];
            end
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_addr] : '0;
    assign out_row   = out_valid ? e_row : 2'd0;
    assign out_col   = out_valid ? e_col : 2'd0;
    assign out_last  = out_valid && (e_q == 4'd8);
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: random and directed matrices
// checked against a queue-based model of buffered matrices.
module tb_systolic_result_drain;

    localparam int unsigned DS    = 8;
    localparam int unsigned EW    = 2 * DS;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic [DS*6-1:0] row_in;
    logic            row_valid;
    logic            flush;
    logic [EW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_row;
    logic [1:0]      out_col;
    logic            out_last;
    logic [LW-1:0]   level;
    logic            overflow;

    systolic_result_drain #(.data_size(DS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .row_valid(row_valid),
        .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [EW-1:0] d;
        logic [1:0]    r;
        logic [1:0]    c;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   committed = 0;
    int   drained   = 0;
    logic exp_ovf   = 1'b0;
    int   rdy_mode  = 0;
    int   cyc       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: 0 stalled, 1 always ready, 2 random, 3 pattern 1,0,0.
    always @(posedge clk) begin
        #2;
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc % 3 == 0);
        endcase
    end

    // Monitor: compares the presented element against the scoreboard head.
    always @(negedge clk) begin
        exp_t x;
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0d with nothing expected", out_data);
                end else begin
                    x = sb[0];
                    check("out_data", 32'(out_data), 32'(x.d));
                    check("out_row",  32'(out_row),  32'(x.r));
                    check("out_col",  32'(out_col),  32'(x.c));
                    check("out_last", 32'(out_last), 32'(x.last));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        if (x.last) drained++;
                    end
                end
            end else begin
                check("idle_data", 32'(out_data), 32'd0);
                check("idle_rc",   32'({out_row, out_col, out_last}), 32'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the row-2 edge.
    task automatic send_matrix(input logic [EW-1:0] m [9], input int gap);
        bit drop;
        exp_t x;
        drop = 1'b0;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, gap)) begin
                row_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (r == 0) begin
                drop = ((committed - drained) == DEPTH);
                if (drop) exp_ovf = 1'b1;
            end
            row_in    = {m[r*3+2], m[r*3+1], m[r*3]};
            row_valid = 1'b1;
            if (r == 2 && !drop) begin
                committed++;
                for (int i = 0; i < 9; i++) begin
                    x.d    = m[i];
                    x.r    = 2'(i / 3);
                    x.c    = 2'(i % 3);
                    x.last = (i == 8);
                    sb.push_back(x);
                end
            end
            @(posedge clk); #1;
        end
        row_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (drained != committed && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", 32'(drained == committed), 32'd1);
        check("drain_level", 32'(level), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        sb.delete();
        committed = 0;
        drained   = 0;
        exp_ovf   = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [EW-1:0] m [9];
        reset = 1'b1; row_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        row_in = '0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        #22 reset = 1'b0;
        @(posedge clk); #1;

        // Single matrix, first element one cycle after the row-2 edge.
        rdy_mode = 1;
        for (int i = 0; i < 9; i++) m[i] = EW'(3 * (i / 3) + 3 - (i % 3));
        send_matrix(m, 0);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_level", 32'(level), 32'd1);
        check("lat_data", 32'(out_data), 32'd3);
        wait_drain(50);

        // Backpressure pattern 1,0,0.
        rdy_mode = 3;
        send_matrix(m, 2);
        wait_drain(100);

        // Overflow: third matrix dropped while stalled.
        rdy_mode = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++) m[i] = EW'(10 * k + i + 1);
            send_matrix(m, 0);
        end
        check("ovf_level", 32'(level), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        rdy_mode = 1;
        wait_drain(100);
        check("ovf_sticky", 32'(overflow), 32'd1);
        pulse_flush();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Commit lands on the same edge as the final-element transfer.
        rdy_mode = 0;
        for (int i = 0; i < 9; i++) m[i] = EW'(31 + i);
        send_matrix(m, 0);
        rdy_mode = 1;
        repeat (6) begin @(posedge clk); #1; end
        for (int i = 0; i < 9; i++) m[i] = EW'(41 + i);
        send_matrix(m, 0);
        check("simul_level", 32'(level), 32'd1);
        check("simul_data", 32'(out_data), 32'd41);
        check("simul_rc", 32'({out_row, out_col}), 32'd0);
        wait_drain(50);

        // Flush discards a partial matrix.
        row_in = {DS*6{1'b1}};
        row_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        row_valid = 1'b0;
        pulse_flush();
        check("flush_level", 32'(level), 32'd0);
        for (int i = 0; i < 9; i++) m[i] = EW'(i + 1);
        send_matrix(m, 0);
        wait_drain(50);

        // Random traffic with random consumer readiness.
        rdy_mode = 2;
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < 9; i++) m[i] = EW'($urandom);
            send_matrix(m, 3);
        end
        wait_drain(3000);
        check("rand_ovf", 32'(overflow), 32'(exp_ovf));

        // Asynchronous reset mid-read.
        rdy_mode = 1;
        for (int i = 0; i < 9; i++) m[i] = EW'(100 + i);
        send_matrix(m, 0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        sb.delete();
        committed = 0;
        drained   = 0;
        exp_ovf   = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) m[i] = EW'(200 + i);
        send_matrix(m, 1);
        wait_drain(50);
        check("final_ovf", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the 3x3 systolic matrix-multiply array.
- Captures the three result rows the array emits on consecutive valid cycles, one row per cycle, and assembles them into a complete 3x3 matrix.
- Buffers up to DEPTH complete matrices.
- Streams buffered elements out one at a time, row-major, over a valid/ready handshake to the next consumer (writeback or serializer).

Parameters:
- data_size, 8, operand width; each result element is 2*data_size bits.
- DEPTH, 2, number of complete 3x3 matrices buffered (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- row_in  input  data_size*6  one result row; element col j at bits [2*data_size*(j+1)-1 : 2*data_size*j].
- row_valid  input  1  row_in valid this cycle; three consecutive-or-not pulses form rows 0,1,2.
- flush  input  1  synchronous clear of all buffered and partial data.
- out_data  output  2*data_size  current element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when high with out_valid.
- out_row  output  2  row index (0..2) of out_data.
- out_col  output  2  column index (0..2) of out_data.
- out_last  output  1  high with the 9th element (row 2, col 2) of a matrix.
- level  output  $clog2(DEPTH+1)  number of complete matrices held.
- overflow  output  1  sticky; a matrix was dropped because the buffer was full.

Behaviour:
- Reset (asynchronous, active-high): all pointers, counters and state cleared. Outputs: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, level=0, overflow=0. Storage contents need not be cleared.
- Write side:
  - wr_row counter 0..2 counts accepted row_valid pulses.
  - Row r of slot wr_ptr is written on the edge where row_valid=1.
  - On the edge writing row 2, the matrix is committed: wr_ptr advances (wraps at DEPTH), level increments, wr_row returns to 0.
  - Gaps between row pulses are allowed; the partial matrix is held indefinitely.
- Drop:
  - If row_valid=1 with wr_row=0 and level==DEPTH, the whole matrix is dropped: overflow<=1, and a drop flag discards the next two rows (rows 1 and 2) with no write and no commit.
  - The full check is done only at row 0. Once row 0 is accepted, the matrix is always committed.
- Read side:
  - out_valid = (level != 0), a registered-state output.
  - Element index e = 0..8 within slot rd_ptr; out_row = e/3, out_col = e%3.
  - out_data is the stored element, presented combinationally from storage.
  - Transfer occurs when out_valid && out_ready; e then increments.
  - On transfer of e=8 (out_last=1): e returns to 0, rd_ptr advances (wraps), and level decrements.
  - While out_valid=0, out_data, out_row and out_col hold 0.
- Latency: a commit edge makes out_valid=1 in the following cycle. The first element is available 1 cycle after the row-2 capture edge.
- Simultaneous commit and final-element transfer on the same edge: level is unchanged and both pointers advance.
- Commit while full is impossible, because drop is decided at row 0.
- A transfer of a matrix during its row 1 or row 2 write frees a slot, but the in-progress matrix is already reserved. Rule: the row-0 acceptance check counts the in-progress matrix, so full means level + (wr_row != 0) == DEPTH.
- flush (synchronous):
  - Clears wr_row, drop flag, e, both pointers and level; clears overflow.
  - flush has priority over row_valid and transfers in the same cycle.
- Reset asserted mid-stream discards all data immediately (asynchronous).
- Width: no arithmetic on data; elements are stored and forwarded bit-exact at 2*data_size.

Test Plan:
- Single matrix: rows {3,2,1},{6,5,4},{9,8,7} (col0 listed first), out_ready=1 -> out_valid rises 1 cycle after the row-2 edge; out_data sequence 3,2,1,6,5,4,9,8,7 with out_row/out_col 0/0..2/2; out_last only on 7; level 1 -> 0.
- Backpressure: same matrix, out_ready toggling 1,0,0,1,... -> out_data/out_row/out_col held stable while stalled; the same 9-value sequence results; no element skipped or repeated.
- Overflow (DEPTH=2, out_ready=0):
  - Write 3 matrices (values 1..9, 11..19, 21..29) -> level=2, overflow=1.
  - Then release out_ready -> output is exactly 1..9 then 11..19; 21..29 is never seen.
- Simultaneous: with level=1 and e=8 and out_ready=1, commit a new matrix on the same edge -> level stays 1; next out_data is row0/col0 of the new matrix.
- Flush/reset: after rows 0 and 1 of a matrix, assert flush for 1 cycle, then write a full matrix 1..9 -> output is only 1..9; assert reset asynchronously mid-read -> out_valid=0 and level=0 immediately, before the next clock edge.
